// File: rtl/fetch_stage_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_ctrl_pkg
// Shared definitions for the instruction-fetch stage controller:
//   - fetch_state_e : FSM state encodings (also driven out on state_o)
//   - DEF_RESET_PC  : default PC loaded by reset
//   - DEF_NOP_INSTR : default instruction word used for bubbles/flushes
//   - PC_INCR       : sequential PC increment
//   - next_fetch_state() : next-state rule shared by RUN, STALL and REDIR
// ---------------------------------------------------------------------------
package fetch_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_REDIR = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR       = 32'd4;

  // Once out of BOOT every state follows the same rule: a stall wins over
  // a redirect, and a redirect wins over sequential fetch.
  function automatic fetch_state_e next_fetch_state(input logic pc_write,
                                                    input logic redirect);
    if (!pc_write)     return ST_STALL;
    else if (redirect) return ST_REDIR;
    else               return ST_RUN;
  endfunction

endpackage

// File: rtl/fetch_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_ctrl_if
// Instruction-memory bus between the fetch stage and the instruction memory.
//   imem_addr_o  : fetch address (driven by the fetch stage, master)
//   imem_rdata_i : instruction word at imem_addr_o, asynchronous read (slave)
// ---------------------------------------------------------------------------
interface fetch_stage_ctrl_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;

  modport master (output imem_addr_o, input  imem_rdata_i);
  modport slave  (input  imem_addr_o, output imem_rdata_i);
endinterface

// File: rtl/fetch_stage_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Width-parameterised event counter that sticks at its all-ones value.
//   clk     : rising-edge clock
//   i_clr   : synchronous clear (dominates i_inc)
//   i_inc   : count one event on this edge
//   o_count : registered count value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_stage_ctrl
// PC register, IF/ID pipeline register and fetch FSM of a 5-stage pipeline.
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   pc_write_i         : 1 = PC may update (0 = stall, overrides redirect)
//   ifid_write_i       : 1 = IF/ID may load
//   ifid_flush_n_i     : 0 = load a NOP bubble into IF/ID
//   redirect_valid_i   : taken jump/branch, target on redirect_pc_i
//   imem               : instruction-memory bus (address out, word in)
//   pc_o               : current PC (imem.imem_addr_o mirrors it)
//   ifid_instr_o/_pc_plus4_o/_valid_o : IF/ID register contents
//   state_o            : FSM state (BOOT=0, RUN=1, STALL=2, REDIR=3)
//   stall_cnt_o        : saturating count of stalled edges
//   flush_cnt_o        : saturating count of IF/ID flush loads
// ---------------------------------------------------------------------------
module fetch_stage_ctrl
  import fetch_stage_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_write_i,
  input  logic                ifid_write_i,
  input  logic                ifid_flush_n_i,
  input  logic                redirect_valid_i,
  input  logic [31:0]         redirect_pc_i,
  fetch_stage_ctrl_if.master  imem,
  output logic [31:0]         pc_o,
  output logic [31:0]         ifid_instr_o,
  output logic [31:0]         ifid_pc_plus4_o,
  output logic                ifid_valid_o,
  output logic [1:0]          state_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_ifid_instr;
  logic [31:0]  r_ifid_pc_plus4;
  logic         r_ifid_valid;

  logic [31:0]  w_pc_plus4;
  logic         w_active;
  logic         w_stall_evt;
  logic         w_flush_evt;

  // 32-bit add wraps naturally: 0xFFFF_FFFC + 4 = 0.
  assign w_pc_plus4  = r_pc + PC_INCR;
  assign w_active    = (r_state != ST_BOOT);
  assign w_stall_evt = w_active && !pc_write_i;
  assign w_flush_evt = w_active && ifid_write_i && !ifid_flush_n_i;

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every register samples the pre-edge values of its neighbours (IF/ID
  // takes the old PC + 4 on the same edge the PC advances).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_BOOT;
      r_pc            <= RESET_PC;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus4 <= '0;
      r_ifid_valid    <= 1'b0;
    end else if (r_state == ST_BOOT) begin
      // One bubble cycle out of reset; the PC and any redirect are ignored.
      r_state         <= ST_RUN;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_valid    <= 1'b0;
    end else begin
      r_state <= next_fetch_state(pc_write_i, redirect_valid_i);

      if (pc_write_i) begin
        r_pc <= redirect_valid_i ? redirect_pc_i : w_pc_plus4;
      end

      if (ifid_write_i) begin
        r_ifid_pc_plus4 <= w_pc_plus4;
        if (!ifid_flush_n_i) begin
          r_ifid_instr <= NOP_INSTR;
          r_ifid_valid <= 1'b0;
        end else begin
          r_ifid_instr <= imem.imem_rdata_i;
          r_ifid_valid <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .i_clr   (reset),
    .i_inc   (w_stall_evt),
    .o_count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .i_clr   (reset),
    .i_inc   (w_flush_evt),
    .o_count (flush_cnt_o)
  );

  assign imem.imem_addr_o = r_pc;
  assign pc_o             = r_pc;
  assign ifid_instr_o     = r_ifid_instr;
  assign ifid_pc_plus4_o  = r_ifid_pc_plus4;
  assign ifid_valid_o     = r_ifid_valid;
  assign state_o          = r_state;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage_ctrl
// Two instances (CNT_W=16 and CNT_W=2) share one directed stimulus stream.
// Each step computes the expected post-edge outputs from a reference model,
// pushes them to a scoreboard queue, and pops/compares after the edge.
// Directed constant checks at the key points back up the model.
// ---------------------------------------------------------------------------
module tb_fetch_stage_ctrl;
  import fetch_stage_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        pc_write_i, ifid_write_i, ifid_flush_n_i, redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_data;

  fetch_stage_ctrl_if bus_a ();
  fetch_stage_ctrl_if bus_b ();
  assign bus_a.imem_rdata_i = imem_data;
  assign bus_b.imem_rdata_i = imem_data;

  logic [31:0] pc_a, instr_a, pp4_a, pc_b, instr_b, pp4_b;
  logic        valid_a, valid_b;
  logic [1:0]  state_a, state_b;
  logic [15:0] stall_a, flush_a;
  logic [1:0]  stall_b, flush_b;

  fetch_stage_ctrl u_dut_a (
    .clk(clk), .reset(reset), .pc_write_i(pc_write_i), .ifid_write_i(ifid_write_i),
    .ifid_flush_n_i(ifid_flush_n_i), .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i), .imem(bus_a.master), .pc_o(pc_a),
    .ifid_instr_o(instr_a), .ifid_pc_plus4_o(pp4_a), .ifid_valid_o(valid_a),
    .state_o(state_a), .stall_cnt_o(stall_a), .flush_cnt_o(flush_a)
  );

  fetch_stage_ctrl #(.CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .pc_write_i(pc_write_i), .ifid_write_i(ifid_write_i),
    .ifid_flush_n_i(ifid_flush_n_i), .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i), .imem(bus_b.master), .pc_o(pc_b),
    .ifid_instr_o(instr_b), .ifid_pc_plus4_o(pp4_b), .ifid_valid_o(valid_b),
    .state_o(state_b), .stall_cnt_o(stall_b), .flush_cnt_o(flush_b)
  );

  typedef struct {
    logic [31:0] pc, instr, pp4;
    logic        valid;
    logic [1:0]  state;
    int          stall, flush, stall2, flush2;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid;
  logic [1:0]  m_state;
  int          m_stall, m_flush, m_stall2, m_flush2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic model_edge(input logic rst, pw, iw, fn, rv, input logic [31:0] rpc);
    exp_t e;
    if (rst) begin
      m_pc = RST_PC; m_instr = NOP; m_pp4 = 32'h0; m_valid = 1'b0; m_state = 2'd0;
      m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
    end else if (m_state == 2'd0) begin
      m_state = 2'd1; m_instr = NOP; m_valid = 1'b0;
    end else begin
      if (!pw) begin
        m_stall  = sat_inc(m_stall, 65535);
        m_stall2 = sat_inc(m_stall2, 3);
      end
      if (iw && !fn) begin
        m_flush  = sat_inc(m_flush, 65535);
        m_flush2 = sat_inc(m_flush2, 3);
      end
      if (iw) begin
        m_pp4 = m_pc + 32'd4;
        if (!fn) begin m_instr = NOP;       m_valid = 1'b0; end
        else     begin m_instr = imem_data; m_valid = 1'b1; end
      end
      if (pw) m_pc = rv ? rpc : m_pc + 32'd4;
      m_state = !pw ? 2'd2 : (rv ? 2'd3 : 2'd1);
    end
    e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid; e.state = m_state;
    e.stall = m_stall; e.flush = m_flush; e.stall2 = m_stall2; e.flush2 = m_flush2;
    sb_q.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("sb_pc",      pc_a,                e.pc);
    check("sb_addr",    bus_a.imem_addr_o,   e.pc);
    check("sb_instr",   instr_a,             e.instr);
    check("sb_pp4",     pp4_a,               e.pp4);
    check("sb_valid",   32'(valid_a),        32'(e.valid));
    check("sb_state",   32'(state_a),        32'(e.state));
    check("sb_stall",   32'(stall_a),        32'(e.stall));
    check("sb_flush",   32'(flush_a),        32'(e.flush));
    check("sb_pc_b",    pc_b,                e.pc);
    check("sb_stall_b", 32'(stall_b),        32'(e.stall2));
    check("sb_flush_b", 32'(flush_b),        32'(e.flush2));
  endtask

  // Drive inputs, predict, take one edge, sample 1 time unit later.
  task automatic step(input logic rst, pw, iw, fn, rv, input logic [31:0] rpc);
    reset = rst; pc_write_i = pw; ifid_write_i = iw; ifid_flush_n_i = fn;
    redirect_valid_i = rv; redirect_pc_i = rpc;
    model_edge(rst, pw, iw, fn, rv, rpc);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  initial begin
    imem_data = 32'h2008_0005;
    m_pc = '0; m_instr = '0; m_pp4 = '0; m_valid = 1'b0; m_state = 2'd0;
    m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;

    // Reset and boot sequence.
    step(1, 1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 1, 0, 32'h0);
    check("rst_state", 32'(state_a), 32'd0);
    check("rst_pc",    pc_a,         RST_PC);
    check("rst_instr", instr_a,      NOP);
    check("rst_pp4",   pp4_a,        32'h0);
    step(0, 1, 1, 1, 0, 32'h0);
    check("boot_to_run", 32'(state_a), 32'd1);
    check("boot_pc_hold", pc_a,        RST_PC);
    check("boot_valid",  32'(valid_a), 32'd0);
    step(0, 1, 1, 1, 0, 32'h0);
    check("first_instr", instr_a,      32'h2008_0005);
    check("first_valid", 32'(valid_a), 32'd1);
    check("first_pp4",   pp4_a,        32'h0040_0004);
    step(0, 1, 1, 1, 0, 32'h0);
    check("seq_pc_8",    pc_a,         32'h0040_0008);
    step(0, 1, 1, 1, 0, 32'h0);
    step(0, 1, 1, 1, 0, 32'h0);
    check("pc_at_10",    pc_a,         32'h0040_0010);

    // Three-cycle stall on PC and IF/ID.
    imem_data = 32'h8C01_0004;
    repeat (3) step(0, 0, 0, 1, 0, 32'h0);
    check("stall_state", 32'(state_a), 32'd2);
    check("stall_pc",    pc_a,         32'h0040_0010);
    check("stall_instr", instr_a,      32'h2008_0005);
    check("stall_cnt3",  32'(stall_a), 32'd3);
    step(0, 1, 1, 1, 0, 32'h0);
    check("unstall_pc",  pc_a,         32'h0040_0014);
    check("unstall_run", 32'(state_a), 32'd1);

    // Redirect with flush.
    step(0, 1, 1, 0, 1, 32'h0040_0100);
    check("redir_pc",    pc_a,         32'h0040_0100);
    check("redir_nop",   instr_a,      NOP);
    check("redir_valid", 32'(valid_a), 32'd0);
    check("redir_flush", 32'(flush_a), 32'd1);
    check("redir_state", 32'(state_a), 32'd3);
    step(0, 1, 1, 1, 0, 32'h0);
    check("redir_run",   32'(state_a), 32'd1);
    check("redir_next",  pc_a,         32'h0040_0104);

    // Redirect during stall is dropped.
    step(0, 0, 1, 1, 1, 32'h0050_0000);
    check("drop_pc",     pc_a,         32'h0040_0104);
    check("drop_state",  32'(state_a), 32'd2);
    step(0, 1, 1, 1, 0, 32'h0);
    check("drop_after",  pc_a,         32'h0040_0108);

    // PC wrap at the top of the address space.
    step(0, 1, 1, 1, 1, 32'hFFFF_FFFC);
    check("wrap_load",   pc_a,         32'hFFFF_FFFC);
    step(0, 1, 1, 1, 0, 32'h0);
    check("wrap_pc",     pc_a,         32'h0000_0000);
    check("wrap_pp4",    pp4_a,        32'h0000_0000);

    // Independent enables: PC advances while IF/ID holds.
    imem_data = 32'h1234_5678;
    step(0, 1, 0, 1, 0, 32'h0);
    check("mix_pc",      pc_a,         32'h0000_0004);
    check("mix_hold",    instr_a,      32'h8C01_0004);

    // Saturation of the narrow counter, then reset mid-stall with redirect.
    repeat (5) step(0, 0, 1, 1, 0, 32'h0);
    check("sat_b",       32'(stall_b), 32'd3);
    check("sat_a",       32'(stall_a), 32'd9);
    step(1, 0, 1, 1, 1, 32'h0060_0000);
    check("rst2_state",  32'(state_a), 32'd0);
    check("rst2_pc",     pc_a,         RST_PC);
    check("rst2_instr",  instr_a,      NOP);
    check("rst2_pp4",    pp4_a,        32'h0);
    check("rst2_valid",  32'(valid_a), 32'd0);
    check("rst2_stall",  32'(stall_a), 32'd0);
    check("rst2_flush",  32'(flush_a), 32'd0);
    check("rst2_stallb", 32'(stall_b), 32'd0);
    step(0, 1, 1, 1, 1, 32'h0060_0000);
    check("rst2_nodir",  pc_a,         RST_PC);
    check("rst2_run",    32'(state_a), 32'd1);
    step(0, 1, 1, 1, 0, 32'h0);
    check("rst2_seq",    pc_a,         32'h0040_0004);

    check("sb_drained",  32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
